// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: drains the TX FIFO through a one-byte prefetch
// register and serialises each character on txd, paced by an external bit tick.
module uart_tx_ctrl (
    input  logic       clk,
    input  logic       rst_,
    input  logic       tx_en,
    input  logic       fifo_rst,
    input  logic       rempty,
    input  logic [7:0] fifo_data,
    output logic       rinc,
    input  logic       bit_tick,
    input  logic [1:0] data_len,
    input  logic       par_en,
    input  logic       par_odd,
    input  logic       stop2,
    input  logic       tx_break,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t     state, state_d;
    logic       hold_vld, pend;
    logic [7:0] hold, shift, shift_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [1:0] len_l;
    logic       par_en_l, stop2_l, par_bit;
    logic       load, char_end, line_d;

    function automatic logic [7:0] len_mask(input logic [1:0] len);
        case (len)
            2'b00:   len_mask = 8'h1F;
            2'b01:   len_mask = 8'h3F;
            2'b10:   len_mask = 8'h7F;
            default: len_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic parity_of(input logic [7:0] data, input logic [1:0] len,
                                       input logic odd);
        parity_of = (^(data & len_mask(len))) ^ odd;
    endfunction

    // At most one read in flight: a strobe is blocked while pend or hold is occupied.
    assign rinc    = tx_en & ~rempty & ~hold_vld & ~pend & ~fifo_rst;
    assign tx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pend     <= 1'b0;
            hold_vld <= 1'b0;
        end else begin
            pend <= rinc;
            if (fifo_rst)
                hold_vld <= 1'b0;
            else if (pend)
                hold_vld <= 1'b1;
            else if (load)
                hold_vld <= 1'b0;
        end
    end

    // Data registers carry no reset; they are only consumed after a load.
    always_ff @(posedge clk) begin
        if (pend && !fifo_rst)
            hold <= fifo_data;
        shift <= shift_d;
        if (load) begin
            len_l    <= data_len;
            par_en_l <= par_en;
            stop2_l  <= stop2;
            par_bit  <= parity_of(hold, data_len, par_odd);
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_cnt_d = bit_cnt;
        load      = 1'b0;
        char_end  = 1'b0;
        line_d    = 1'b1;
        case (state)
            IDLE:   load = bit_tick & hold_vld;
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d   = shift >> 1;
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == ({1'b0, len_l} + 3'd4))
                        state_d = par_en_l ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (bit_tick)
                    state_d = STOP1;
            end
            STOP1: begin
                if (bit_tick) begin
                    if (stop2_l)
                        state_d = STOP2;
                    else
                        char_end = 1'b1;
                end
            end
            STOP2: begin
                if (bit_tick)
                    char_end = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (char_end) begin
            state_d = IDLE;
            load    = hold_vld;
        end
        if (load) begin
            state_d = START;
            shift_d = hold;
        end
        // txd is registered, so it follows the state being entered.
        case (state_d)
            IDLE:    line_d = 1'b1;
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
            PARITY:  line_d = par_bit;
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            txd     <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            txd     <= line_d & ~tx_break;
            tx_done <= char_end;
        end
    end

endmodule
